rv32_d_imm_encode: RTL

//  Inverse of the decode-stage immediate extender: builds 32-bit RV32 instruction words from

---
 rtl/rv32_d_imm_encode.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rv32_d_imm_encode.sv
// RV32 instruction word builder: packs fields plus an immediate into I/S/B/J/U words,
// range-checks the immediate, and expands LI into LUI(+ADDI) over two output beats.
module rv32_d_imm_encode #(
    parameter bit LI_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_imm_src_i,
    input  logic [6:0]  req_opcode_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [31:0] req_imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_err_o,
    output logic        instr_last_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned HI_W  = 20;
    localparam logic [6:0]  OP_LUI  = 7'b0110111;
    localparam logic [6:0]  OP_ADDI = 7'b0010011;

    localparam logic [2:0] SRC_I  = 3'b000;
    localparam logic [2:0] SRC_S  = 3'b001;
    localparam logic [2:0] SRC_B  = 3'b010;
    localparam logic [2:0] SRC_J  = 3'b011;
    localparam logic [2:0] SRC_U  = 3'b100;
    localparam logic [2:0] SRC_LI = 3'b101;

    typedef enum logic {
        IDLE,
        LI2
    } state_t;

    state_t            state_q;
    logic              valid_q;
    logic [XLEN-1:0]   instr_q;
    logic              err_q;
    logic              last_q;
    logic [XLEN-1:0]   pend_q;

    logic [XLEN-1:0]   enc_word;
    logic              enc_err;
    logic              enc_last;
    logic              enc_two;
    logic [XLEN-1:0]   enc_pend;
    logic [HI_W-1:0]   li_hi;
    logic              fits12;

    logic [31:0] imm;
    assign imm = req_imm_i;

    // Immediate fits a sign-extended 12-bit field.
    assign fits12 = (imm[31:11] == {21{imm[11]}});

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        enc_last = 1'b1;
        enc_two  = 1'b0;
        enc_pend = '0;
        li_hi    = '0;
        case (req_imm_src_i)
            SRC_I: begin
                enc_word = {imm[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
                enc_err  = !fits12;
            end
            SRC_S: begin
                enc_word = {imm[11:5], req_rs2_i, req_rs1_i, req_funct3_i, imm[4:0], req_opcode_i};
                enc_err  = !fits12;
            end
            SRC_B: begin
                enc_word = {imm[12], imm[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                            imm[4:1], imm[11], req_opcode_i};
                enc_err  = imm[0] || (imm[31:12] != {20{imm[12]}});
            end
            SRC_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], req_rd_i, req_opcode_i};
                enc_err  = imm[0] || (imm[31:20] != {12{imm[20]}});
            end
            SRC_U: begin
                enc_word = {imm[31:12], req_rd_i, req_opcode_i};
                enc_err  = (imm[11:0] != 12'd0);
            end
            SRC_LI: begin
                if (LI_EN) begin
                    if (fits12) begin
                        enc_word = {imm[11:0], 5'd0, 3'b000, req_rd_i, OP_ADDI};
                    end else begin
                        // ADDI sign-extends its immediate, so round the upper part up when bit 11 is set.
                        li_hi    = imm[31:12] + HI_W'(imm[11]);
                        enc_word = {li_hi, req_rd_i, OP_LUI};
                        if (imm[11:0] != 12'd0) begin
                            enc_last = 1'b0;
                            enc_two  = 1'b1;
                            enc_pend = {imm[11:0], req_rd_i, 3'b000, req_rd_i, OP_ADDI};
                        end
                    end
                end else begin
                    enc_err = 1'b1;
                end
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    assign req_ready_o   = !rst_i && (state_q == IDLE) && (!valid_q || instr_ready_i);
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_err_o   = err_q;
    assign instr_last_o  = last_q;

    // Output register and IDLE/LI2 sequencing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            pend_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        valid_q <= 1'b1;
                        instr_q <= enc_word;
                        err_q   <= enc_err;
                        last_q  <= enc_last;
                        if (enc_two) begin
                            pend_q  <= enc_pend;
                            state_q <= LI2;
                        end
                    end else if (instr_ready_i) begin
                        valid_q <= 1'b0;
                    end
                end
                LI2: begin
                    if (!valid_q || instr_ready_i) begin
                        valid_q <= 1'b1;
                        instr_q <= pend_q;
                        err_q   <= 1'b0;
                        last_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
